rf_wb_arbiter: RTL and testbench

Write-back arbiter for the single write port of the 32x32 register file. Collects register-write requests from up to NREQ producers (ALU result, load data, multi-cycle unit) through valid/ready handshakes and grants one per cycle in round-robin order. Drives the register file's write address, data and enable from a registered output stage. Optionally tracks per-register pending writes in a scoreboard for the issue-stage hazard check.

---
 rtl/rf_wb_arbiter_pkg.sv | 10 +
 rtl/rf_wb_arbiter_rr_arbiter.sv | 33 +++
 rtl/rf_wb_arbiter.sv | 106 ++++++++++
 tb/tb_rf_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin grant logic: picks the first valid requester at or after ptr,
// searching upward modulo N. Purely combinational; the caller owns ptr.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] winner
);

  logic found;
  int   idx;

  // Scan the N positions starting at ptr and keep the first valid one.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && valid[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        winner      = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the single register-file write port.
// Grants one requester per cycle in round-robin order and registers the
// winning address/data into the write-back stage (register 0 never written).
// Optional feature macro: RF_WB_SCOREBOARD_EN adds the per-register busy
// scoreboard with its reservation port.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = rf_wb_arbiter_pkg::DW,
  parameter int AW   = rf_wb_arbiter_pkg::AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [AW-1:0]     wb_addr,
  output logic [DW-1:0]     wb_data,
  output logic              wb_en
`ifdef RF_WB_SCOREBOARD_EN
  ,
  input  logic              rsv_valid,
  input  logic [AW-1:0]     rsv_addr,
  output logic              rsv_ready,
  output logic [31:0]       busy
`endif
);

  import rf_wb_arbiter_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   winner;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(.N(NREQ)) u_rr (
    .valid  (req_valid),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner)
  );

  // No grant may escape while reset is held low.
  assign req_ready = grant & {NREQ{reset}};
  assign xfer      = |req_ready;
  assign sel_addr  = req_addr[int'(winner)*AW +: AW];
  assign sel_data  = req_data[int'(winner)*DW +: DW];

  // Priority pointer moves just past the winner after each transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    end
  end

  // Registered write-back stage; address and data hold when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else if (xfer) begin
      wb_en   <= (sel_addr != ZERO_REG);
      wb_addr <= sel_addr;
      wb_data <= sel_data;
    end else begin
      wb_en   <= 1'b0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  assign rsv_ready = ~busy_q[rsv_addr];
  assign busy      = busy_q;

  // Clear on write-back transfer, then set on reservation so set wins.
  always_comb begin
    busy_d = busy_q;
    if (xfer && (sel_addr != ZERO_REG)) begin
      busy_d[sel_addr] = 1'b0;
    end
    if (rsv_valid && rsv_ready && (rsv_addr != ZERO_REG)) begin
      busy_d[rsv_addr] = 1'b1;
    end
  end

  // Pending-write vector; a flop bank small enough to reset outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus randomized
// requesters, all compared against a behavioural model of the arbiter.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       wb_addr;
  logic [DW-1:0]       wb_data;
  logic                wb_en;
`ifdef RF_WB_SCOREBOARD_EN
  logic                rsv_valid;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ready;
  logic [31:0]         busy;
`endif

  rf_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .wb_en     (wb_en)
`ifdef RF_WB_SCOREBOARD_EN
    ,
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .rsv_ready (rsv_ready),
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  bit          m_wb_en;
  bit [AW-1:0] m_wb_addr;
  bit [DW-1:0] m_wb_data;
  bit [31:0]   m_busy;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_wb_en   = 0;
    m_wb_addr = '0;
    m_wb_data = '0;
    m_busy    = '0;
  endtask

  task automatic set_req(input int i, input bit v, input bit [AW-1:0] a, input bit [DW-1:0] d);
    req_valid[i]           = v;
    req_addr[i*AW +: AW]   = a;
    req_data[i*DW +: DW]   = d;
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic step(output int w);
    bit          exp_rsv_rdy;
    bit [AW-1:0] a;
    logic [NREQ-1:0] exp_rdy;
    w = -1;
    #3;
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && req_valid[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    end
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_rsv_rdy = 1'b0;
`ifdef RF_WB_SCOREBOARD_EN
    exp_rsv_rdy = !m_busy[rsv_addr];
    check("rsv_ready", 64'(rsv_ready), 64'(exp_rsv_rdy));
`endif
    @(posedge clk);
    if (w >= 0) begin
      a         = req_addr[w*AW +: AW];
      m_wb_en   = (a != 0);
      m_wb_addr = a;
      m_wb_data = req_data[w*DW +: DW];
      m_ptr     = (w + 1) % NREQ;
      if (a != 0) m_busy[a] = 1'b0;
    end else begin
      m_wb_en = 0;
    end
`ifdef RF_WB_SCOREBOARD_EN
    if (rsv_valid && exp_rsv_rdy && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
`endif
    #1;
    check("wb_en",   64'(wb_en),   64'(m_wb_en));
    check("wb_addr", 64'(wb_addr), 64'(m_wb_addr));
    check("wb_data", 64'(wb_data), 64'(m_wb_data));
`ifdef RF_WB_SCOREBOARD_EN
    check("busy", 64'(busy), 64'(m_busy));
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  int w;
  int first;
  bit [NREQ-1:0] pending;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef RF_WB_SCOREBOARD_EN
    rsv_valid = 1'b0;
    rsv_addr  = '0;
`endif
    model_reset();

    // Reset state: no grant even with every requester valid
    req_valid = '1;
    #3;
    check("rst_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    check("rst_wb_en",   64'(wb_en),   64'(0));
    check("rst_wb_addr", 64'(wb_addr), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
`ifdef RF_WB_SCOREBOARD_EN
    check("rst_busy", 64'(busy), 64'(0));
`endif
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single requester 1
    set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
    step(w);
    check("single_winner", 64'(w), 64'(1));
    set_req(1, 1'b0, 5'd0, 32'h0);
    check("single_wb_en",   64'(wb_en),   64'(1));
    check("single_wb_data", 64'(wb_data), 64'(32'hDEADBEEF));
    step(w);

    // Full contention from reset: 0,1,2,0,1,2
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'(32'hA000 + i));
    for (int c = 0; c < 6; c++) begin
      step(w);
      check("rr_order", 64'(w), 64'(c % NREQ));
      check("rr_wb_en", 64'(wb_en), 64'(1));
    end
    req_valid = '0;
    step(w);

    // Write to register 0 is consumed but not enabled
    set_req(0, 1'b1, 5'd0, 32'h1234);
    step(w);
    check("zero_winner", 64'(w), 64'(0));
    check("zero_wb_en",  64'(wb_en), 64'(0));
    set_req(0, 1'b0, 5'd0, 32'h0);
    step(w);

`ifdef RF_WB_SCOREBOARD_EN
    // Reserve r5, then re-request (blocked), then clear by write, then set+clear together
    rsv_valid = 1'b1;
    rsv_addr  = 5'd5;
    step(w);
    check("sb_set", 64'(busy[5]), 64'(1));
    step(w);
    check("sb_blocked", 64'(rsv_ready), 64'(0));
    rsv_valid = 1'b0;
    set_req(2, 1'b1, 5'd5, 32'h55);
    step(w);
    check("sb_clear", 64'(busy[5]), 64'(0));
    rsv_valid = 1'b1;
    step(w);
    check("sb_set_wins", 64'(busy[5]), 64'(1));
    rsv_valid = 1'b0;
    set_req(2, 1'b0, 5'd0, 32'h0);
    step(w);
`endif

    // Reset mid-operation with requesters 0 and 2 valid
    set_req(0, 1'b1, 5'd3, 32'h3333);
    set_req(2, 1'b1, 5'd9, 32'h9999);
`ifdef RF_WB_SCOREBOARD_EN
    rsv_valid = 1'b1;
    rsv_addr  = 5'd12;
`endif
    step(w);
    check("mid_wb_en_pre", 64'(wb_en), 64'(1));
    reset = 1'b0;
    model_reset();
    #1;
    check("mid_wb_en",  64'(wb_en),     64'(0));
    check("mid_ready",  64'(req_ready), 64'(0));
`ifdef RF_WB_SCOREBOARD_EN
    check("mid_busy",   64'(busy),      64'(0));
    rsv_valid = 1'b0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(w);
    check("mid_first", 64'(w), 64'(0));

    // Fairness: park pointer at 2, then requester 1 waits behind 2 and 0
    req_valid = '0;
    set_req(1, 1'b1, 5'd11, 32'h1111);
    step(w);
    check("fair_setup", 64'(w), 64'(1));
    set_req(0, 1'b1, 5'd3, 32'h3333);
    set_req(2, 1'b1, 5'd9, 32'h9999);
    first = -1;
    for (int c = 0; c < NREQ; c++) begin
      step(w);
      if (w == 1 && first < 0) first = c;
    end
    check("fair_wait", 64'(first), 64'(NREQ - 1));
    req_valid = '0;
    step(w);

    // Randomized requesters that hold stable until granted
    pending = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && ($urandom % 3 == 0)) begin
          pending[i] = 1'b1;
          set_req(i, 1'b1, ($urandom % 6 == 0) ? 5'd0 : 5'($urandom), 32'($urandom));
        end
      end
`ifdef RF_WB_SCOREBOARD_EN
      rsv_valid = 1'($urandom);
      rsv_addr  = 5'($urandom);
`endif
      step(w);
      if (w >= 0) begin
        pending[w] = 1'b0;
        req_valid[w] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
